// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequential fetch, EX-stage redirect, and same-cycle squash of IF/ID and ID/EX.
// The BSRAM word on pc_if arrives one cycle after its address; a stall freezes fetch, but a redirect overrides it.
module pc_redirect_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic [31:0]      ex_target,
   output logic [31:0]      imem_addr,
   output logic             imem_en,
   output logic [31:0]      pc_if,
   output logic             if_valid,
   output logic             flush_id,
   output logic             flush_ex,
   output logic [CNT_W-1:0] taken_count,
   output logic             misalign_err
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      SQUASH = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   redirect;

   assign redirect = ex_valid & ex_is_branch;

   assign imem_en  = ~stall | redirect;
   assign flush_id = redirect & ~rst;
   assign flush_ex = redirect & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // A stall holds whatever state is current, so the flag on the held BSRAM word stays consistent.
   always_comb begin
      state_nxt = state;
      if_valid  = 1'b0;
      case (state)
         BOOT: begin
            if_valid = 1'b0;
            if (redirect) begin
               state_nxt = SQUASH;
            end else if (!stall) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if_valid = 1'b1;
            if (redirect) begin
               state_nxt = SQUASH;
            end
         end
         SQUASH: begin
            if_valid = 1'b0;
            if (redirect) begin
               state_nxt = SQUASH;
            end else if (!stall) begin
               state_nxt = RUN;
            end
         end
         default: begin
            if_valid  = 1'b0;
            state_nxt = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         imem_addr <= RESET_PC;
         pc_if     <= RESET_PC;
      end else if (redirect) begin
         imem_addr <= {ex_target[31:2], 2'b00};
         pc_if     <= imem_addr;
      end else if (!stall) begin
         imem_addr <= imem_addr + 32'd4;
         pc_if     <= imem_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         taken_count  <= '0;
         misalign_err <= 1'b0;
      end else if (redirect) begin
         if (taken_count != {CNT_W{1'b1}}) begin
            taken_count <= taken_count + CNT_W'(1);
         end
         if (ex_target[1:0] != 2'b00) begin
            misalign_err <= 1'b1;
         end
      end
   end

endmodule
